// File: rtl/sync_sender_pkg.sv
// -----------------------------------------------------------------------------
// sync_sender_pkg
// Shared definitions for the sync_sender block: default data width and the
// handshake FSM state encoding, which must match the encoding the downstream
// sync_multi logic and debug tooling expect.
// -----------------------------------------------------------------------------
package sync_sender_pkg;

    // Default word width; must agree with sync_multi's in_data width.
    localparam int DATA_WIDTHS = 8;

    // Width of the FSM state encoding.
    localparam int STATE_WIDTH = 2;

    // 4-phase handshake FSM states.
    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE  = 2'd0,  // waiting for a word and for f to be released
        SETUP = 2'd1,  // tx_data loaded, v still low for setup margin
        REQ   = 2'd2,  // v high, waiting for f to rise
        REL   = 2'd3   // v low again, waiting for f to fall
    } state_t;

endpackage : sync_sender_pkg

// File: rtl/sync_sender_fifo.sv
// -----------------------------------------------------------------------------
// sender_fifo
// Small synchronous FIFO buffering producer words ahead of the handshake FSM.
// The head word is visible combinationally on dout so the FSM can capture it
// into its output register on the same edge that pops it.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (empties the FIFO)
//   push   in   write din (ignored when full)
//   pop    in   remove head word (ignored when empty)
//   din    in   DATA_WIDTH write data
//   dout   out  DATA_WIDTH head word (combinational)
//   count  out  number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module sender_fifo
    import sync_sender_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTHS,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Qualify requests so an overflow or underflow can never corrupt state.
    always_comb begin
        push_ok_s = push && (count_r != CNT_FULL);
        pop_ok_s  = pop  && (count_r != CNT_ZERO);
    end

    // Storage array; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule : sender_fifo

// File: rtl/sync_sender.sv
// -----------------------------------------------------------------------------
// sync_sender
// Sender side of a 4-phase (return-to-zero) handshake feeding sync_multi.
// Producer words enter through a valid/ready port into sender_fifo. The FSM
// loads one word into tx_data, waits a setup cycle, raises v, waits for f to
// rise, drops v, waits for f to fall, then counts the transfer.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   wr_data   in   DATA_WIDTH producer word
//   wr_valid  in   producer offers wr_data
//   wr_ready  out  FIFO not full
//   tx_data   out  DATA_WIDTH registered word to sync_multi.in_data
//   v         out  registered request to sync_multi.v
//   f         in   acknowledge from sync_multi (already clk-synchronous)
//   busy      out  transfer in progress or words pending
//   sent_cnt  out  CNT_WIDTH count of completed handshakes (wraps)
// -----------------------------------------------------------------------------
module sync_sender
    import sync_sender_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTHS,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  v,
    input  logic                  f,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  sent_cnt
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [FCNT_W-1:0]    FCNT_ZERO = FCNT_W'(0);
    localparam logic [FCNT_W-1:0]    FCNT_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] SENT_ONE  = CNT_WIDTH'(1);

    state_t                state_r;
    state_t                state_s;

    logic [FCNT_W-1:0]     count_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  v_next_s;
    logic                  sent_inc_s;

    logic [DATA_WIDTH-1:0] tx_data_r;
    logic                  v_r;
    logic [CNT_WIDTH-1:0]  sent_cnt_r;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign wr_ready = (count_s != FCNT_FULL);
    assign push_s   = wr_valid && wr_ready;

    sender_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wr_data),
        .dout  (head_s),
        .count (count_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic. IDLE also waits for f low so a stale acknowledge
    // left over from an aborted handshake is never taken as a new one.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if ((count_s != FCNT_ZERO) && !f) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s = REQ;
            end
            REQ: begin
                if (f) begin
                    state_s = REL;
                end else begin
                    state_s = REQ;
                end
            end
            REL: begin
                if (!f) begin
                    state_s = IDLE;
                end else begin
                    state_s = REL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM output decode: FIFO pop/load, next request level, counter strobe.
    always_comb begin
        pop_s      = 1'b0;
        v_next_s   = 1'b0;
        sent_inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                pop_s = (count_s != FCNT_ZERO) && !f;
            end
            SETUP: begin
                v_next_s = 1'b1;
            end
            REQ: begin
                v_next_s = !f;
            end
            REL: begin
                sent_inc_s = !f;
            end
            default: begin
                pop_s      = 1'b0;
                v_next_s   = 1'b0;
                sent_inc_s = 1'b0;
            end
        endcase
    end

    // Output data register: loads only on IDLE->SETUP, so it is stable
    // for the whole handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data_r <= '0;
        end else if (pop_s) begin
            tx_data_r <= head_s;
        end
    end

    // Request register; the async reset drops v immediately on abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_r <= 1'b0;
        end else begin
            v_r <= v_next_s;
        end
    end

    // Completed-handshake counter, advanced on REL->IDLE, wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_cnt_r <= '0;
        end else if (sent_inc_s) begin
            sent_cnt_r <= sent_cnt_r + SENT_ONE;
        end
    end

    assign tx_data  = tx_data_r;
    assign v        = v_r;
    assign sent_cnt = sent_cnt_r;
    assign busy     = (state_r != IDLE) || (count_s != FCNT_ZERO);

endmodule : sync_sender

// File: tb/tb_sync_sender.sv
// -----------------------------------------------------------------------------
// tb_sync_sender
// Self-checking bench. A receiver model answers v with f delayed by three
// cycles. Accepted producer words go into an expected queue; a monitor pops
// one word on every rising edge of v and compares tx_data, and also checks
// tx_data holds steady while v or f is high. Transfer counts are checked
// against the number of words accepted since reset, modulo 2^CNT_WIDTH.
// -----------------------------------------------------------------------------
module tb_sync_sender;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] tx_data;
    logic          v;
    logic          f        = 1'b0;
    logic          busy;
    logic [CW-1:0] sent_cnt;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q [$];
    int            n_acc  = 0;      // words accepted since last reset
    logic          f_hold = 1'b0;   // receiver forced to hold f high
    logic [2:0]    vh     = 3'b000; // receiver's view of v history

    always #5 clk = ~clk;

    sync_sender #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_data  (tx_data),
        .v        (v),
        .f        (f),
        .busy     (busy),
        .sent_cnt (sent_cnt)
    );

    // Receiver: f follows v three clock edges later, updated just after the edge.
    always @(posedge clk) begin
        #2;
        vh = {vh[1:0], v};
        if (f_hold) f = 1'b1;
        else        f = vh[2];
    end

    // Monitor: scoreboard pop on each v rise, plus tx_data stability check.
    logic          v_p = 1'b0;
    logic          f_p = 1'b0;
    logic          r_p = 1'b0;
    logic [DW-1:0] tx_p = '0;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (reset && r_p) begin
            if (v && !v_p) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: tx_data=%h with no word expected", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        fails++;
                        $display("FAIL sb_order: tx_data=%h expected %h", tx_data, e);
                    end
                end
            end
            if ((v_p || f_p) && (v || f)) begin
                tests++;
                if (tx_data !== tx_p) begin
                    fails++;
                    $display("FAIL tx_stable: tx_data=%h changed from %h during handshake", tx_data, tx_p);
                end
            end
        end
        v_p  = v;
        f_p  = f;
        tx_p = tx_data;
        r_p  = reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one word; returns just after the edge that accepted it.
    task automatic push_word(input logic [DW-1:0] d);
        bit acc = 1'b0;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            wr_data  = d;
            wr_valid = 1'b1;
            if (wr_ready) begin
                acc = 1'b1;
                exp_q.push_back(d);
                n_acc++;
            end
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: word %h never accepted", d);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        n_acc = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Wait for all words to be sent, then check counters and idle flags.
    task automatic drain(input string name);
        bit done = 1'b0;
        logic [CW-1:0] es;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!busy && !f && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy=%0b queue=%0d", name, busy, exp_q.size());
        end
        es = n_acc[CW-1:0];
        check({name, "_sent_cnt"}, 32'(sent_cnt), 32'(es));
        check({name, "_busy"},     32'(busy),     32'd0);
        check({name, "_wr_ready"}, 32'(wr_ready), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        logic [DW-1:0] w;

        // Reset state, checked while reset is still held low.
        #1;
        check("rst_v",        32'(v),           32'd0);
        check("rst_tx_data",  32'(tx_data),     32'd0);
        check("rst_sent_cnt", 32'(sent_cnt),    32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_wr_ready", 32'(wr_ready),    32'd1);
        check("rst_count",    32'(dut.count_s), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single word: latency of tx_data and v, v drop after f, count 1.
        push_word(8'h5A);
        idle_in();
        @(negedge clk);
        check("lat_tx_data", 32'(tx_data), 32'h5A);
        check("lat_v_setup", 32'(v),       32'd0);
        @(negedge clk);
        check("lat_v_req",   32'(v),       32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (f) seen = 1'b1;
        end
        check("lat_f_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("lat_v_drop", 32'(v), 32'd0);
        drain("single");

        // Back-to-back 01..05: FIFO fills after the 5th offer.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            w = DW'(i);
            push_word(w);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check("b2b_full_ready", 32'(wr_ready), 32'd0);
        drain("b2b");

        // f held high after reset release: no transfer until it falls.
        @(negedge clk);
        f_hold = 1'b1;
        f      = 1'b1;
        do_reset();
        push_word(8'hC3);
        idle_in();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("fhold_v",       32'(v),       32'd0);
            check("fhold_tx_data", 32'(tx_data), 32'd0);
        end
        f_hold = 1'b0;
        f      = 1'b0;
        drain("fhold");

        // Reset during REQ with two words still queued.
        do_reset();
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        idle_in();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (v) seen = 1'b1;
        end
        check("abort_req_seen", 32'(seen),        32'd1);
        check("abort_queued",   32'(dut.count_s), 32'd2);
        #2;
        reset = 1'b0;
        exp_q.delete();
        n_acc = 0;
        #1;
        check("abort_v_async", 32'(v), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_count",    32'(dut.count_s), 32'd0);
        check("abort_sent_cnt", 32'(sent_cnt),    32'd0);
        check("abort_busy",     32'(busy),        32'd0);
        check("abort_wr_ready", 32'(wr_ready),    32'd1);
        repeat (6) @(negedge clk);

        // Push and pop in the same cycle with three words stored.
        @(negedge clk);
        f_hold = 1'b1;
        f      = 1'b1;
        do_reset();
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        @(negedge clk);
        check("pp_count_before", 32'(dut.count_s), 32'd3);
        f_hold   = 1'b0;
        f        = 1'b0;
        wr_data  = 8'h44;
        wr_valid = 1'b1;
        check("pp_ready", 32'(wr_ready), 32'd1);
        exp_q.push_back(8'h44);
        n_acc++;
        @(negedge clk);
        wr_valid = 1'b0;
        check("pp_count_after", 32'(dut.count_s), 32'd3);
        check("pp_head_loaded", 32'(tx_data),     32'h11);
        drain("pushpop");

        // Random words with random producer gaps.
        for (int i = 0; i < 20; i++) begin
            w = DW'($urandom_range(0, 255));
            push_word(w);
            if ($urandom_range(0, 1) == 1) begin
                idle_in();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        idle_in();
        drain("random");

        // Counter wrap with CNT_WIDTH=4: 16 transfers read 0, 17 read 1.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            w = DW'($urandom_range(0, 255));
            push_word(w);
        end
        idle_in();
        drain("wrap16");
        check("wrap16_zero", 32'(sent_cnt), 32'd0);
        push_word(8'hE7);
        idle_in();
        drain("wrap17");
        check("wrap17_one", 32'(sent_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sync_sender
